// File: rtl/mig_app_pkg.sv
// Shared constants and types for the MIG application-port arbiter.
// The command encodings match the MIG 7-series app_cmd field.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // One 256-bit word spans 8 MIG address units.
  localparam int ADDR_LSB = 3;

  typedef enum logic [1:0] {
    S_CALIB = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/tag_fifo.sv
// 1-bit-wide synchronous FIFO that remembers which client issued each read.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   ui_clk,
  input  logic                   sys_rst,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_app_arbiter.sv
// Round-robin sharing of the single MIG app_* port between the sample loader
// (client 0) and the playback engine (client 1), with in-order read return routing.
module mig_app_arbiter
  import mig_app_pkg::*;
#(
  parameter int ADDR_W   = 29,
  parameter int DATA_W   = 256,
  parameter int WADDR_W  = 26,
  parameter int RD_DEPTH = 16
) (
  input  logic                        ui_clk,
  input  logic                        sys_rst,
  input  logic                        init_calib_complete,

  input  logic                        c0_req,
  input  logic                        c0_we,
  input  logic [WADDR_W-1:0]          c0_addr,
  input  logic [DATA_W-1:0]           c0_wdata,
  output logic                        c0_ack,
  output logic                        c0_rvalid,

  input  logic                        c1_req,
  input  logic                        c1_we,
  input  logic [WADDR_W-1:0]          c1_addr,
  input  logic [DATA_W-1:0]           c1_wdata,
  output logic                        c1_ack,
  output logic                        c1_rvalid,

  output logic [DATA_W-1:0]           rdata,

  output logic [ADDR_W-1:0]           app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  output logic [DATA_W-1:0]           app_wdf_data,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [DATA_W/8-1:0]         app_wdf_mask,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic [DATA_W-1:0]           app_rd_data,
  input  logic                        app_rd_data_valid,

  output logic [$clog2(RD_DEPTH):0]   rd_outstanding,
  output logic                        err_unexp_rd
);

  state_t state;

  logic rr_last;
  logic cur_id;
  logic cur_we;
  logic cmd_done;
  logic dat_done;

  logic elig0;
  logic elig1;
  logic grant_valid;
  logic grant_id;
  logic sel_we;
  logic [WADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic cmd_acc;
  logic dat_acc;
  logic cmd_fin;
  logic dat_fin;
  logic issue_done;

  logic fifo_push;
  logic fifo_pop;
  logic fifo_dout;
  logic fifo_full;
  logic fifo_empty;

  // Reads are held back while the tag FIFO cannot record another outstanding id.
  always_comb begin
    elig0       = c0_req && (c0_we || !fifo_full);
    elig1       = c1_req && (c1_we || !fifo_full);
    grant_valid = elig0 || elig1;
    grant_id    = (elig0 && elig1) ? ~rr_last : elig1;
    sel_we      = grant_id ? c1_we    : c0_we;
    sel_addr    = grant_id ? c1_addr  : c0_addr;
    sel_wdata   = grant_id ? c1_wdata : c0_wdata;
  end

  // Command and write data may be accepted in different cycles; finish when both are in.
  always_comb begin
    cmd_acc    = app_en && app_rdy;
    dat_acc    = app_wdf_wren && app_wdf_rdy;
    cmd_fin    = cmd_done || cmd_acc;
    dat_fin    = dat_done || dat_acc || !cur_we;
    issue_done = (state == S_ISSUE) && cmd_fin && dat_fin;
    c0_ack     = issue_done && !cur_id;
    c1_ack     = issue_done && cur_id;
    fifo_push  = (state == S_ISSUE) && cmd_acc && !cur_we;
    fifo_pop   = app_rd_data_valid && !fifo_empty;
  end

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state        <= S_CALIB;
      rr_last      <= 1'b1;
      cur_id       <= 1'b0;
      cur_we       <= 1'b0;
      cmd_done     <= 1'b0;
      dat_done     <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= CMD_READ;
      app_addr     <= '0;
      app_wdf_data <= '0;
    end else begin
      case (state)
        S_CALIB: begin
          if (init_calib_complete) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!init_calib_complete) begin
            state <= S_CALIB;
          end else if (grant_valid) begin
            rr_last      <= grant_id;
            cur_id       <= grant_id;
            cur_we       <= sel_we;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            app_en       <= 1'b1;
            app_cmd      <= sel_we ? CMD_WRITE : CMD_READ;
            app_addr     <= ADDR_W'({sel_addr, {ADDR_LSB{1'b0}}});
            app_wdf_wren <= sel_we;
            if (sel_we) begin
              app_wdf_data <= sel_wdata;
            end
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_acc) begin
            app_en <= 1'b0;
          end
          if (dat_acc) begin
            app_wdf_wren <= 1'b0;
          end
          if (issue_done) begin
            cmd_done <= 1'b0;
            dat_done <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cmd_done <= cmd_fin;
            dat_done <= dat_done || dat_acc;
          end
        end
        default: state <= S_CALIB;
      endcase
    end
  end

  // Read data comes back in issue order, so the FIFO head names its owner.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rdata        <= '0;
      c0_rvalid    <= 1'b0;
      c1_rvalid    <= 1'b0;
      err_unexp_rd <= 1'b0;
    end else begin
      rdata     <= app_rd_data;
      c0_rvalid <= fifo_pop && !fifo_dout;
      c1_rvalid <= fifo_pop && fifo_dout;
      if (app_rd_data_valid && fifo_empty) begin
        err_unexp_rd <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_tag_fifo (
    .ui_clk  (ui_clk),
    .sys_rst (sys_rst),
    .push    (fifo_push),
    .din     (cur_id),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rd_outstanding)
  );

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter: inputs change 1 time unit after the rising
// edge, outputs are compared on the falling edge of the same cycle.
module tb_mig_app_arbiter;
  import mig_app_pkg::*;

  localparam int ADDR_W   = 29;
  localparam int DATA_W   = 256;
  localparam int WADDR_W  = 26;
  localparam int RD_DEPTH = 16;

  logic                 ui_clk;
  logic                 sys_rst;
  logic                 init_calib_complete;
  logic                 c0_req, c0_we, c1_req, c1_we;
  logic [WADDR_W-1:0]   c0_addr, c1_addr;
  logic [DATA_W-1:0]    c0_wdata, c1_wdata;
  logic                 c0_ack, c1_ack, c0_rvalid, c1_rvalid;
  logic [DATA_W-1:0]    rdata;
  logic [ADDR_W-1:0]    app_addr;
  logic [2:0]           app_cmd;
  logic                 app_en, app_wdf_wren, app_wdf_end;
  logic [DATA_W-1:0]    app_wdf_data;
  logic [DATA_W/8-1:0]  app_wdf_mask;
  logic                 app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [DATA_W-1:0]    app_rd_data;
  logic [$clog2(RD_DEPTH):0] rd_outstanding;
  logic                 err_unexp_rd;

  int passed;
  int total;

  mig_app_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WADDR_W  (WADDR_W),
    .RD_DEPTH (RD_DEPTH)
  ) dut (
    .ui_clk              (ui_clk),
    .sys_rst             (sys_rst),
    .init_calib_complete (init_calib_complete),
    .c0_req              (c0_req),
    .c0_we               (c0_we),
    .c0_addr             (c0_addr),
    .c0_wdata            (c0_wdata),
    .c0_ack              (c0_ack),
    .c0_rvalid           (c0_rvalid),
    .c1_req              (c1_req),
    .c1_we               (c1_we),
    .c1_addr             (c1_addr),
    .c1_wdata            (c1_wdata),
    .c1_ack              (c1_ack),
    .c1_rvalid           (c1_rvalid),
    .rdata               (rdata),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .rd_outstanding      (rd_outstanding),
    .err_unexp_rd        (err_unexp_rd)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge ui_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int id, input logic req, input logic we,
                               input logic [WADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (id == 0) begin
      c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wdata;
    end else begin
      c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wdata;
    end
  endtask

  task automatic applyReset();
    sys_rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    app_rd_data_valid = 1'b0;
    step();
    step();
    sys_rst = 1'b1;
    step();
  endtask

  // Returns the id of the first client acked within the budget, -1 on timeout.
  task automatic wait_ack(output int id);
    id = -1;
    for (int n = 0; n < 10; n++) begin
      sample();
      if (c0_ack) begin id = 0; break; end
      if (c1_ack) begin id = 1; break; end
      step();
    end
  endtask

  function automatic logic [DATA_W-1:0] dval(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    return {8{w}};
  endfunction

  initial begin
    int id;
    int cnt;
    int exp_id [4];
    logic [DATA_W-1:0] wdat;

    passed = 0;
    total  = 0;
    ui_clk = 1'b0;
    sys_rst = 1'b0;
    init_calib_complete = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;

    // Reset values
    step();
    step();
    sample();
    checkOutput("rst_app_en", app_en, 1'b0);
    checkOutput("rst_wren", app_wdf_wren, 1'b0);
    checkOutput("rst_cmd", app_cmd, CMD_READ);
    checkOutput("rst_addr", app_addr, '0);
    checkOutput("rst_wdata", app_wdf_data, '0);
    checkOutput("rst_ack", {c0_ack, c1_ack, c0_rvalid, c1_rvalid}, 4'b0000);
    checkOutput("rst_rdata", rdata, '0);
    checkOutput("rst_outstanding", rd_outstanding, '0);
    checkOutput("rst_err", err_unexp_rd, 1'b0);
    checkOutput("rst_state", dut.state, S_CALIB);
    checkOutput("rst_mask", app_wdf_mask, '0);

    // Write held off until calibration completes
    wdat = dval(77);
    step();
    sys_rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 26'd5, wdat);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (app_en || c0_ack) cnt++;
      step();
    end
    checkOutput("calib_hold_no_en", cnt, 0);
    init_calib_complete = 1'b1;
    sample();
    checkOutput("calib_edge_en", app_en, 1'b0);
    step();
    sample();
    checkOutput("idle_en", app_en, 1'b0);
    step();
    sample();
    checkOutput("wr_app_en", app_en, 1'b1);
    checkOutput("wr_wren", app_wdf_wren, 1'b1);
    checkOutput("wr_end", app_wdf_end, 1'b1);
    checkOutput("wr_addr", app_addr, 29'h28);
    checkOutput("wr_cmd", app_cmd, CMD_WRITE);
    checkOutput("wr_wdata", app_wdf_data, wdat);
    checkOutput("wr_acks", {c0_ack, c1_ack}, 2'b10);
    step();
    applyStimulus(0, 1'b0, 1'b1, 26'd5, wdat);
    sample();
    checkOutput("wr_after_en", app_en, 1'b0);
    checkOutput("wr_after_wren", app_wdf_wren, 1'b0);
    checkOutput("wr_after_ack", c0_ack, 1'b0);

    // Both clients reading continuously: grants alternate starting with client 0
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 26'd7, '0);
    applyStimulus(1, 1'b1, 1'b0, 26'd9, '0);
    exp_id = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      wait_ack(id);
      checkOutput($sformatf("rr_grant%0d", k), id, exp_id[k]);
      checkOutput($sformatf("rr_cmd%0d", k), app_cmd, CMD_READ);
      checkOutput($sformatf("rr_addr%0d", k), app_addr, (exp_id[k] == 0) ? 29'h38 : 29'h48);
      step();
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    sample();
    checkOutput("rr_outstanding", rd_outstanding, 5'd4);

    // Returns routed in issue order: c0, c1, c0, c1
    for (int i = 0; i < 4; i++) begin
      step();
      app_rd_data_valid = 1'b1;
      app_rd_data = dval(i);
      sample();
      if (i > 0) begin
        checkOutput($sformatf("ret%0d_rv", i-1), {c0_rvalid, c1_rvalid}, (exp_id[i-1] == 0) ? 2'b10 : 2'b01);
        checkOutput($sformatf("ret%0d_data", i-1), rdata, dval(i-1));
      end
    end
    step();
    app_rd_data_valid = 1'b0;
    sample();
    checkOutput("ret3_rv", {c0_rvalid, c1_rvalid}, 2'b01);
    checkOutput("ret3_data", rdata, dval(3));
    checkOutput("ret_outstanding", rd_outstanding, '0);

    // Write data stalled 3 cycles after the command is taken
    step();
    wdat = dval(55);
    applyStimulus(0, 1'b1, 1'b1, 26'd3, wdat);
    app_wdf_rdy = 1'b0;
    sample();
    checkOutput("wst_idle_en", app_en, 1'b0);
    step();
    sample();
    checkOutput("wst_c1_en_wren", {app_en, app_wdf_wren, c0_ack}, 3'b110);
    step();
    sample();
    checkOutput("wst_c2_en_wren", {app_en, app_wdf_wren, c0_ack}, 3'b010);
    step();
    sample();
    checkOutput("wst_c3_en_wren", {app_en, app_wdf_wren, c0_ack}, 3'b010);
    step();
    app_wdf_rdy = 1'b1;
    sample();
    checkOutput("wst_c4_en_wren", {app_en, app_wdf_wren, c0_ack}, 3'b011);
    checkOutput("wst_c4_data", app_wdf_data, wdat);
    step();
    c0_req = 1'b0;
    sample();
    checkOutput("wst_after", {app_en, app_wdf_wren, c0_ack}, 3'b000);

    // Tag FIFO full: 17th read waits for one return
    applyStimulus(1, 1'b1, 1'b0, 26'd11, '0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      wait_ack(id);
      if (id == 1) cnt++;
      step();
    end
    checkOutput("full_acks", cnt, 16);
    sample();
    checkOutput("full_outstanding", rd_outstanding, 5'd16);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      sample();
      if (c1_ack || app_en) cnt++;
    end
    checkOutput("full_no_grant", cnt, 0);
    step();
    app_rd_data_valid = 1'b1;
    app_rd_data = dval(99);
    sample();
    checkOutput("full_rv_early", c1_rvalid, 1'b0);
    step();
    app_rd_data_valid = 1'b0;
    sample();
    checkOutput("full_rv", {c0_rvalid, c1_rvalid}, 2'b01);
    checkOutput("full_rdata", rdata, dval(99));
    checkOutput("full_pop_count", rd_outstanding, 5'd15);
    step();
    sample();
    checkOutput("full_17th", {app_en, c1_ack}, 2'b11);
    step();
    c1_req = 1'b0;
    sample();
    checkOutput("full_refill", rd_outstanding, 5'd16);
    cnt = 0;
    for (int n = 0; n < 18; n++) begin
      step();
      app_rd_data_valid = (n < 16);
      sample();
      if (c1_rvalid) cnt++;
    end
    checkOutput("drain_rv_count", cnt, 16);
    checkOutput("drain_outstanding", rd_outstanding, '0);
    checkOutput("drain_no_err", err_unexp_rd, 1'b0);

    // Unexpected read data sets a sticky error
    step();
    app_rd_data_valid = 1'b1;
    sample();
    checkOutput("unexp_err_early", err_unexp_rd, 1'b0);
    step();
    app_rd_data_valid = 1'b0;
    sample();
    checkOutput("unexp_err", err_unexp_rd, 1'b1);
    checkOutput("unexp_rv", {c0_rvalid, c1_rvalid}, 2'b00);
    checkOutput("unexp_count", rd_outstanding, '0);
    step();
    step();
    step();
    sample();
    checkOutput("unexp_sticky", err_unexp_rd, 1'b1);

    // Asynchronous reset while a command is stalled in issue
    step();
    app_rdy = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 26'd1, dval(5));
    sample();
    step();
    sample();
    checkOutput("arst_pre_en", app_en, 1'b1);
    step();
    sample();
    checkOutput("arst_stall", {app_en, c0_ack}, 2'b10);
    sys_rst = 1'b0;
    #1;
    checkOutput("arst_en", app_en, 1'b0);
    checkOutput("arst_wren", app_wdf_wren, 1'b0);
    checkOutput("arst_err", err_unexp_rd, 1'b0);
    checkOutput("arst_cmd", app_cmd, CMD_READ);
    checkOutput("arst_state", dut.state, S_CALIB);
    c0_req = 1'b0;
    app_rdy = 1'b1;
    step();
    sys_rst = 1'b1;
    sample();
    checkOutput("arst_release_en", app_en, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
